// File: rtl/sid_write_sched_pkg.sv
// Shared SID definitions: register map, waveform bits, writer states, bus word.
package sid_pkg;

  // SID voice register offsets
  localparam logic [2:0] REG_FREQ = 3'd0;
  localparam logic [2:0] REG_PW   = 3'd2;
  localparam logic [2:0] REG_ATK  = 3'd4;
  localparam logic [2:0] REG_SUS  = 3'd5;
  localparam logic [2:0] REG_WAV  = 3'd6;

  // WAV register bits
  localparam logic [7:0] WAVE_GATE  = 8'h01;
  localparam logic [7:0] WAVE_SYNC  = 8'h02;
  localparam logic [7:0] WAVE_RING  = 8'h04;
  localparam logic [7:0] WAVE_TEST  = 8'h08;
  localparam logic [7:0] WAVE_TRI   = 8'h10;
  localparam logic [7:0] WAVE_SAW   = 8'h20;
  localparam logic [7:0] WAVE_PULSE = 8'h40;
  localparam logic [7:0] WAVE_NOISE = 8'h80;

  // Note-sequence progress: which of the three locked writes is in flight
  localparam logic [1:0] SEQ_IDLE = 2'd0;
  localparam logic [1:0] SEQ_W1   = 2'd1;
  localparam logic [1:0] SEQ_W2   = 2'd2;
  localparam logic [1:0] SEQ_W3   = 2'd3;

  // Host grants allowed back-to-back while others wait
  localparam logic [1:0] HOST_BURST = 2'd2;

  typedef enum logic [1:0] {
    WR_IDLE   = 2'd0,
    WR_SETUP  = 2'd1,
    WR_STROBE = 2'd2,
    WR_HOLD   = 2'd3
  } wr_state_e;

  typedef struct packed {
    logic [2:0] addr;
    logic [1:0] voice;
    logic [7:0] data;
  } sid_wr_t;

endpackage

// File: rtl/sid_write_sched_if.sv
// Host, note and SID bus signals of the write scheduler.
interface sid_write_sched_if;
  logic       host_valid;
  logic       host_ready;
  logic [2:0] host_addr;
  logic [1:0] host_voice;
  logic [7:0] host_data;

  logic       note_valid;
  logic       note_ready;
  logic [1:0] note_voice;
  logic [7:0] note_freq;
  logic [7:0] note_wave;
  logic [7:0] note_len;

  logic [2:0] sid_addr;
  logic [1:0] sid_voice;
  logic [7:0] sid_data;
  logic       sid_we;

  // scheduler side
  modport slave (
    input  host_valid, host_addr, host_voice, host_data,
    input  note_valid, note_voice, note_freq, note_wave, note_len,
    output host_ready, note_ready,
    output sid_addr, sid_voice, sid_data, sid_we
  );

  // requester / bus observer side
  modport master (
    output host_valid, host_addr, host_voice, host_data,
    output note_valid, note_voice, note_freq, note_wave, note_len,
    input  host_ready, note_ready,
    input  sid_addr, sid_voice, sid_data, sid_we
  );
endinterface

// File: rtl/sid_bus_writer.sv
// Three-cycle SID bus write engine: SETUP (we=0), STROBE (we=1), HOLD (we=0).
module sid_bus_writer
  import sid_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      start_i,
  input  sid_wr_t   wr_i,
  output logic      can_grant_o,
  output wr_state_e state_o,
  output sid_wr_t   bus_o,
  output logic      we_o
);

  wr_state_e state_q, state_d;
  sid_wr_t   bus_q;
  logic      we_q;

  // A new write may only be loaded while idle or in the last cycle of a write
  assign can_grant_o = (state_q == WR_IDLE) || (state_q == WR_HOLD);
  assign state_o     = state_q;
  assign bus_o       = bus_q;
  assign we_o        = we_q;

  // Fixed walk through the write phases; HOLD chains straight into the next write
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:   state_d = start_i ? WR_SETUP : WR_IDLE;
      WR_SETUP:  state_d = WR_STROBE;
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD:   state_d = start_i ? WR_SETUP : WR_IDLE;
      default:   state_d = WR_IDLE;
    endcase
  end

  // Bus word latched at grant so it is steady from SETUP through HOLD
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WR_IDLE;
      bus_q   <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= (state_q == WR_SETUP);
      if (start_i && can_grant_o) bus_q <= wr_i;
    end
  end

endmodule

// File: rtl/sid_write_sched.sv
// SID write scheduler: arbitrates host writes, note sequences and gate releases
// onto a single three-cycle SID bus writer; owns the tick and gate timers.
module sid_write_sched
  import sid_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         tick_div_i,
  output logic                busy_o,
  sid_write_sched_if.slave    sid_if
);

  localparam int NV = 2;  // voices that own a gate timer

  logic            wr_can, wr_go, wr_we;
  wr_state_e       wr_state;
  sid_wr_t         wr_req, wr_bus;

  logic [1:0]      seq_q, seq_d;
  logic            nv_q, nv_d;
  logic [7:0]      nfreq_q, nfreq_d, nwave_q, nwave_d, nlen_q, nlen_d;
  logic [1:0]      hcnt_q, hcnt_d;
  logic [15:0]     tcnt_q, tcnt_d;
  logic            tick;
  logic [NV-1:0][7:0] gate_q, gate_d, wave_q, wave_d;
  logic [NV-1:0]   rel_q, rel_d;

  logic gnt_cont, gnt_host, gnt_rel, gnt_note, rel_v, note_live, fin_hold;

  // voices 2/3 are acknowledged but have no writes or timers
  assign note_live = ~sid_if.note_voice[1];
  // last cycle of the third locked write: arm that voice's gate timer
  assign fin_hold  = (seq_q == SEQ_W3) && (wr_state == WR_HOLD);

  // Grant arbitration, evaluated only when the writer can take a new write
  always_comb begin
    gnt_cont = 1'b0;
    gnt_host = 1'b0;
    gnt_rel  = 1'b0;
    gnt_note = 1'b0;
    rel_v    = ~rel_q[0];
    if (rst_n && wr_can) begin
      if (seq_q == SEQ_W1 || seq_q == SEQ_W2)
        gnt_cont = 1'b1;
      else if (sid_if.host_valid &&
               !(hcnt_q == HOST_BURST && ((|rel_q) || sid_if.note_valid)))
        gnt_host = 1'b1;
      else if (|rel_q)
        gnt_rel = 1'b1;
      else if (sid_if.note_valid)
        gnt_note = 1'b1;
    end
  end

  // Bus word for whichever source won
  always_comb begin
    wr_req = '0;
    if (gnt_cont && seq_q == SEQ_W1) begin
      wr_req.addr  = REG_FREQ;
      wr_req.voice = {1'b0, nv_q};
      wr_req.data  = nfreq_q;
    end else if (gnt_cont) begin
      wr_req.addr  = REG_WAV;
      wr_req.voice = {1'b0, nv_q};
      wr_req.data  = nwave_q | WAVE_GATE;
    end else if (gnt_host) begin
      wr_req.addr  = sid_if.host_addr;
      wr_req.voice = sid_if.host_voice;
      wr_req.data  = sid_if.host_data;
    end else if (gnt_rel) begin
      wr_req.addr  = REG_WAV;
      wr_req.voice = {1'b0, rel_v};
      wr_req.data  = wave_q[rel_v] & ~WAVE_GATE;
    end else if (gnt_note) begin
      wr_req.addr  = REG_WAV;
      wr_req.voice = sid_if.note_voice;
      wr_req.data  = sid_if.note_wave & ~WAVE_GATE;
    end
  end

  assign wr_go = gnt_cont | gnt_host | gnt_rel | (gnt_note & note_live);

  // Next state for sequence lock, fairness count, tick divider and gate timers
  always_comb begin
    seq_d   = seq_q;
    nv_d    = nv_q;
    nfreq_d = nfreq_q;
    nwave_d = nwave_q;
    nlen_d  = nlen_q;
    hcnt_d  = hcnt_q;
    gate_d  = gate_q;
    wave_d  = wave_q;
    rel_d   = rel_q;
    tick    = (tcnt_q >= tick_div_i);
    tcnt_d  = tick ? 16'd0 : tcnt_q + 16'd1;

    if (gnt_note && note_live) begin
      seq_d   = SEQ_W1;
      nv_d    = sid_if.note_voice[0];
      nfreq_d = sid_if.note_freq;
      nwave_d = sid_if.note_wave;
      nlen_d  = sid_if.note_len;
    end else if (gnt_cont) begin
      seq_d = seq_q + 2'd1;
    end else if (fin_hold) begin
      seq_d = SEQ_IDLE;
    end

    if (gnt_host)
      hcnt_d = (hcnt_q == HOST_BURST) ? HOST_BURST : hcnt_q + 2'd1;
    else if (gnt_rel || gnt_note)
      hcnt_d = 2'd0;

    for (int v = 0; v < NV; v++) begin
      if (gnt_note && sid_if.note_voice == 2'(v)) begin
        // a fresh note cancels whatever the old one still had pending
        gate_d[v] = 8'd0;
        rel_d[v]  = 1'b0;
      end else if (fin_hold && nv_q == 1'(v)) begin
        // reload takes precedence over a same-cycle tick
        gate_d[v] = nlen_q;
        wave_d[v] = nwave_q;
      end else begin
        if (tick && gate_q[v] != 8'd0) gate_d[v] = gate_q[v] - 8'd1;
        if (gnt_rel && rel_v == 1'(v))
          rel_d[v] = 1'b0;
        else if (tick && gate_q[v] == 8'd1)
          rel_d[v] = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q   <= SEQ_IDLE;
      nv_q    <= 1'b0;
      nfreq_q <= '0;
      nwave_q <= '0;
      nlen_q  <= '0;
      hcnt_q  <= '0;
      tcnt_q  <= '0;
      gate_q  <= '0;
      wave_q  <= '0;
      rel_q   <= '0;
    end else begin
      seq_q   <= seq_d;
      nv_q    <= nv_d;
      nfreq_q <= nfreq_d;
      nwave_q <= nwave_d;
      nlen_q  <= nlen_d;
      hcnt_q  <= hcnt_d;
      tcnt_q  <= tcnt_d;
      gate_q  <= gate_d;
      wave_q  <= wave_d;
      rel_q   <= rel_d;
    end
  end

  sid_bus_writer u_writer (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (wr_go),
    .wr_i        (wr_req),
    .can_grant_o (wr_can),
    .state_o     (wr_state),
    .bus_o       (wr_bus),
    .we_o        (wr_we)
  );

  assign sid_if.host_ready = gnt_host;
  assign sid_if.note_ready = gnt_note;
  assign sid_if.sid_addr   = wr_bus.addr;
  assign sid_if.sid_voice  = wr_bus.voice;
  assign sid_if.sid_data   = wr_bus.data;
  assign sid_if.sid_we     = wr_we;

  assign busy_o = rst_n & ((wr_state != WR_IDLE) | (seq_q != SEQ_IDLE) | (|rel_q) |
                           sid_if.host_valid | sid_if.note_valid);

endmodule

// File: tb/tb_sid_write_sched.sv
// Directed scoreboard bench for sid_write_sched.
module tb_sid_write_sched;
  import sid_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] tick_div;
  logic        busy;

  sid_write_sched_if sif();

  sid_write_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_div_i (tick_div),
    .busy_o     (busy),
    .sid_if     (sif)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  logic [12:0] exp_q[$];
  int          stb_q[$];
  bit          mon_en = 1'b0;
  logic [12:0] prev_bus = '0;
  logic        prev_we = 1'b0;
  logic [12:0] mon_cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: strobe width, setup/hold stability, scoreboard compare
  always @(negedge clk) begin
    mon_cur = {sif.sid_addr, sif.sid_voice, sif.sid_data};
    if (mon_en) begin
      if (sif.sid_we) begin
        chk("we_single", {31'd0, prev_we}, 0);
        chk("setup_bus", {19'd0, mon_cur}, {19'd0, prev_bus});
        wr_cnt++;
        stb_q.push_back(cyc);
        chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 1);
        if (exp_q.size() != 0) chk("sb_write", {19'd0, mon_cur}, {19'd0, exp_q.pop_front()});
      end else if (prev_we) begin
        chk("hold_bus", {19'd0, mon_cur}, {19'd0, prev_bus});
      end
    end
    prev_we  = sif.sid_we;
    prev_bus = mon_cur;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_send(input logic [2:0] a, input logic [1:0] v, input logic [7:0] d,
                           input bit keep, output int gc, output int n);
    n = 0;
    sif.host_valid = 1'b1;
    sif.host_addr  = a;
    sif.host_voice = v;
    sif.host_data  = d;
    do begin @(negedge clk); n++; end while (!sif.host_ready && n < 100);
    chk("host_hs", {31'd0, sif.host_ready}, 1);
    gc = cyc;
    if (sif.host_ready) exp_q.push_back({a, v, d});
    step();
    if (!keep) sif.host_valid = 1'b0;
  endtask

  task automatic note_send(input logic [1:0] v, input logic [7:0] f, input logic [7:0] w,
                           input logic [7:0] l, output int ac);
    int n;
    n = 0;
    sif.note_valid = 1'b1;
    sif.note_voice = v;
    sif.note_freq  = f;
    sif.note_wave  = w;
    sif.note_len   = l;
    do begin @(negedge clk); n++; end while (!sif.note_ready && n < 100);
    chk("note_hs", {31'd0, sif.note_ready}, 1);
    ac = cyc;
    if (sif.note_ready && !v[1]) begin
      exp_q.push_back({3'd6, v, w & 8'hFE});
      exp_q.push_back({3'd0, v, f});
      exp_q.push_back({3'd6, v, w | 8'h01});
    end
    step();
    sif.note_valid = 1'b0;
  endtask

  task automatic wait_stb(input int k, input int lim, input string tag);
    int n;
    n = 0;
    while (stb_q.size() < k && n < lim) begin @(negedge clk); n++; end
    chk(tag, stb_q.size(), k);
  endtask

  initial begin
    int gc, n, ac, ac2, gap, w0;
    sif.host_valid = 1'b1;  // requests present during reset must be ignored
    sif.host_addr  = '0;
    sif.host_voice = '0;
    sif.host_data  = '0;
    sif.note_valid = 1'b1;
    sif.note_voice = '0;
    sif.note_freq  = '0;
    sif.note_wave  = '0;
    sif.note_len   = '0;
    tick_div       = 16'd9;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {31'd0, sif.sid_we}, 0);
    chk("rst_bus", {19'd0, sif.sid_addr, sif.sid_voice, sif.sid_data}, 0);
    chk("rst_hrdy", {31'd0, sif.host_ready}, 0);
    chk("rst_nrdy", {31'd0, sif.note_ready}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    sif.host_valid = 1'b0;
    sif.note_valid = 1'b0;
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Single host write: same-cycle ready, strobe two cycles after grant
    stb_q.delete();
    host_send(3'd0, 2'd0, 8'd17, 1'b0, gc, n);
    chk("h_same_cycle", n, 1);
    repeat (4) @(negedge clk);
    chk("h_stb_cnt", stb_q.size(), 1);
    if (stb_q.size() == 1) chk("h_stb_lat", stb_q[0] - gc, 2);
    chk("h_idle_busy", {31'd0, busy}, 0);

    // Note sequence timing and release window
    stb_q.delete();
    step();
    note_send(2'd1, 8'd22, 8'h40, 8'd3, ac);
    exp_q.push_back({3'd6, 2'd1, 8'h40});
    wait_stb(4, 200, "n_stb_cnt");
    repeat (60) @(negedge clk);
    chk("n_stb_total", stb_q.size(), 4);
    if (stb_q.size() >= 4) begin
      chk("n_stb0", stb_q[0] - ac, 2);
      chk("n_stb1", stb_q[1] - ac, 5);
      chk("n_stb2", stb_q[2] - ac, 8);
      gap = stb_q[3] - stb_q[2] - 3;
      chk("rel_window", {31'd0, gap >= 20 && gap <= 40}, 1);
    end
    chk("n_idle_busy", {31'd0, busy}, 0);

    // Voice 2 note: acknowledged, no writes
    w0 = wr_cnt;
    step();
    note_send(2'd2, 8'd1, 8'h11, 8'd4, ac);
    repeat (20) @(negedge clk);
    chk("v2_no_write", wr_cnt - w0, 0);

    // Zero-length note never releases
    tick_div = 16'd0;
    stb_q.delete();
    step();
    note_send(2'd0, 8'd7, 8'h11, 8'd0, ac);
    wait_stb(3, 50, "z_stb_cnt");
    w0 = wr_cnt;
    repeat (1000) @(negedge clk);
    chk("z_no_release", wr_cnt - w0, 0);
    chk("z_busy", {31'd0, busy}, 0);

    // Retrigger before expiry: single release timed from the second note
    tick_div = 16'd9;
    stb_q.delete();
    step();
    note_send(2'd0, 8'd5, 8'h20, 8'd10, ac);
    wait_stb(3, 50, "rt_first");
    repeat (20) @(negedge clk);
    step();
    note_send(2'd0, 8'd9, 8'h80, 8'd3, ac2);
    exp_q.push_back({3'd6, 2'd0, 8'h80});
    repeat (200) @(negedge clk);
    chk("rt_stb_total", stb_q.size(), 7);
    if (stb_q.size() >= 7) begin
      gap = stb_q[6] - stb_q[5] - 3;
      chk("rt_window", {31'd0, gap >= 20 && gap <= 40}, 1);
    end

    // Continuous host traffic against a note and its release
    tick_div = 16'd0;
    stb_q.delete();
    step();
    fork
      begin
        int hgc, hn;
        for (int i = 0; i < 5; i++) begin
          host_send(3'd4, 2'd0, 8'hA0 + 8'(i), i < 4, hgc, hn);
          if (i == 3) exp_q.push_back({3'd6, 2'd0, 8'h20});
        end
      end
      begin
        int nac;
        note_send(2'd0, 8'h33, 8'h21, 8'd1, nac);
      end
    join
    wait_stb(9, 200, "f_stb_cnt");
    repeat (10) @(negedge clk);
    chk("f_busy", {31'd0, busy}, 0);

    // Reset during the first strobe of a note sequence
    tick_div = 16'd9;
    step();
    note_send(2'd1, 8'h44, 8'h10, 8'd2, ac);
    n = 0;
    while (!sif.sid_we && n < 50) begin @(negedge clk); n++; end
    chk("r_saw_stb", {31'd0, sif.sid_we}, 1);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    @(negedge clk);
    chk("r_we_off", {31'd0, sif.sid_we}, 0);
    chk("r_bus_off", {19'd0, sif.sid_addr, sif.sid_voice, sif.sid_data}, 0);
    chk("r_busy_off", {31'd0, busy}, 0);
    step();
    rst_n = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    w0 = wr_cnt;
    repeat (60) @(negedge clk);
    chk("r_no_leftover", wr_cnt - w0, 0);
    chk("r_busy_after", {31'd0, busy}, 0);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sid_write_sched.md
SID_WRITE_SCHED -- requirements
Module: sid_write_sched

Interface
REQ-001 Clock is clk and reset is rst_n: one clock, synchronous, active-low.
REQ-002 clk  in  1  system clock (5 MHz nominal).
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 host_valid / host_ready  in / out  1 / 1  host write request handshake.
REQ-005 host_addr, host_voice, host_data  in  3, 2, 8  host register address, voice, data.
REQ-006 note_valid / note_ready  in / out  1 / 1  note-event handshake.
REQ-007 note_voice, note_freq, note_wave, note_len  in  2, 8, 8, 8  target voice, FREQ value, WAV value (bit0 ignored), gate length in ticks.
REQ-008 tick_div  in  16  tick period minus one, in clk cycles.
REQ-009 sid_addr, sid_voice, sid_data, sid_we  out  3, 2, 8, 1  SID register write bus.
REQ-010 busy  out  1  high while any write is in flight or any request is pending.

Function
REQ-011 Each SID write SHALL take exactly 3 cycles: SETUP (bus driven, we=0), STROBE (we=1), HOLD (we=0, same bus values).
REQ-012 Writer states SHALL be IDLE, SETUP, STROBE, HOLD; HOLD goes to SETUP if a grant was made in HOLD, otherwise to IDLE.
REQ-013 Grants SHALL be evaluated in IDLE and HOLD only; a granted write enters SETUP the next cycle, giving one write per 3 cycles sustained.
REQ-014 Grant priority SHALL be: locked note-sequence continuation, then host, then pending releases (voice 0 before voice 1), then new note start.
REQ-015 Fairness: after 2 consecutive host grants, if a release or note is pending, the next grant SHALL go to it.
REQ-016 host_ready SHALL be high only in the cycle a host grant is made; the transfer occurs on host_valid and host_ready.
REQ-017 note_ready SHALL be high only in the cycle a note-start grant is made.
REQ-018 An accepted note SHALL issue three locked writes: WAV=note_wave&~0x01, FREQ=note_freq, WAV=note_wave|0x01, all to note_voice.
REQ-019 With a note accepted at cycle t, STROBEs SHALL occur at t+2, t+5 and t+8.
REQ-020 At the final HOLD, that voice's 8-bit gate counter SHALL load note_len and its stored wave SHALL load note_wave.
REQ-021 Tick generator: a 16-bit counter SHALL produce a one-cycle tick every tick_div+1 cycles; tick_div=0 gives a tick every cycle.
REQ-022 On a tick, each nonzero gate counter SHALL decrement; a 1->0 transition SHALL set that voice's release-pending flag.
REQ-023 A release write SHALL be WAV=stored_wave&~0x01 and SHALL clear release-pending when granted.
REQ-024 note_len=0 SHALL never produce a release.
REQ-025 Counter reload SHALL win over a simultaneous tick decrement.
REQ-026 Accepting a note for a voice SHALL clear that voice's release-pending flag and suppress any old release.
REQ-027 note_voice 2 or 3 SHALL be accepted (note_ready pulses) and produce no writes.
REQ-028 Bus outputs SHALL be registered and stable from SETUP through HOLD.

Reset
REQ-029 While rst_n=0: writer IDLE; sid_we, sid_addr, sid_voice, sid_data, host_ready, note_ready and busy 0; all counters, flags, lock and fairness count cleared.
REQ-030 Reset asserted mid-write SHALL drive sid_we=0 from the next cycle; a partial note sequence SHALL be abandoned and not resumed.

Structure
REQ-031 Shared package sid_pkg SHALL hold register addresses (FREQ=0, PW=2, ATK=4, SUS=5, WAV=6), waveform bit constants (GATE=0x01 ... NOISE=0x80) and the writer state enum.
REQ-032 The 3-cycle writer SHALL be one sub-module, sid_bus_writer; arbitration, tick generation and gate counters live in the top.

Verification
REQ-033 Idle, host write addr=0 voice=0 data=17 -> host_ready same cycle; sid_we high for exactly 1 cycle, 2 cycles later; bus stable for 3 cycles.
REQ-034 tick_div=9, note voice=1 freq=22 wave=0x40 len=3 -> writes (6,1,0x40), (0,1,22), (6,1,0x41); release (6,1,0x40) granted 30+/-10 cycles after the final HOLD.
REQ-035 Release pending and host_valid held continuously -> release granted after at most 2 host writes; host never interleaves inside a note sequence.
REQ-036 Note with len=0 -> no release write over 1000 ticks.
REQ-037 Same voice re-triggered before expiry -> counter reloads; exactly one release write, timed from the second note.
REQ-038 rst_n low during STROBE -> sid_we=0 next cycle; after release of reset, no leftover writes and busy=0.
